// File: rtl/vga_pkg.sv
// Shared definitions for the APB VGA framebuffer: register map, bit positions,
// pixel type and frame-geometry helpers.
package vga_pkg;

  typedef logic [23:0] pixel_t;

  // Register select, taken from paddr[3:2] inside the register window.
  typedef enum logic [1:0] {
    RegCtrl     = 2'd0,
    RegStatus   = 2'd1,
    RegFrameCnt = 2'd2,
    RegBgColor  = 2'd3
  } reg_sel_e;

  localparam int unsigned CtrlEnBit       = 0;
  localparam int unsigned CtrlIrqEnBit    = 1;
  localparam int unsigned StatusVblankBit = 0;
  localparam int unsigned StatusIrqBit    = 1;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel divider, x/y raster counters, linear scan address and sync/valid generation.
// All outputs describe the current counter state; the top level adds the pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned FB_AW    = 19,
  parameter int unsigned PIX_DIV  = 1,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  output logic [FB_AW:0] scan_addr,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           vblank,
  output logic           vblank_evt
);

  localparam int unsigned HTotal = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned XW     = $clog2(HTotal);
  localparam int unsigned YW     = $clog2(VTotal);
  localparam int unsigned DW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0]  div_q, div_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [FB_AW:0] addr_q, addr_d;
  logic           pix_en, x_last, y_last, x_act, y_act, hs_reg, vs_reg;

  always_comb begin
    pix_en = (div_q == DW'(PIX_DIV - 1));
    x_last = (x_q == XW'(HTotal - 1));
    y_last = (y_q == YW'(VTotal - 1));
    x_act  = (x_q < XW'(H_ACTIVE));
    y_act  = (y_q < YW'(V_ACTIVE));
    hs_reg = (x_q >= XW'(H_ACTIVE + H_FP)) && (x_q <= XW'(H_ACTIVE + H_FP + H_SYNC - 1));
    vs_reg = (y_q >= YW'(V_ACTIVE + V_FP)) && (y_q <= YW'(V_ACTIVE + V_FP + V_SYNC - 1));

    div_d  = div_q;
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (!enable) begin
      div_d  = '0;
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else begin
      div_d = pix_en ? '0 : div_q + 1'b1;
      if (pix_en) begin
        x_d = x_last ? '0 : x_q + 1'b1;
        if (x_last) y_d = y_last ? '0 : y_q + 1'b1;
        // Saturate past the top so out-of-range pixels stay flagged until frame wrap.
        if (x_last && y_last)                     addr_d = '0;
        else if (x_act && y_act && !addr_q[FB_AW]) addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign scan_addr  = addr_q;
  assign active     = enable & x_act & y_act;
  assign hsync      = (enable & hs_reg) ? SYNC_POL : ~SYNC_POL;
  assign vsync      = (enable & vs_reg) ? SYNC_POL : ~SYNC_POL;
  assign vblank     = (y_q >= YW'(V_ACTIVE));
  assign vblank_evt = enable & pix_en & x_last & (y_q == YW'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_fb_apb.sv
// APB VGA framebuffer controller: APB decode, control/status registers, dual-port
// framebuffer RAM and the two-stage scanout pipeline to the pins.
module vga_fb_apb
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned FB_AW    = 19,
  parameter int unsigned PIX_DIV  = 1,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [2:0]  in_pprot,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_valid,
  output logic        irq
);

  logic             access, fb_sel, reg_err, done, rd_done, reg_we, fb_we;
  logic [FB_AW-1:0] word_idx;
  reg_sel_e         reg_sel;
  logic             fb_wait_q, fb_wait_d;
  logic [31:0]      reg_rdata, rd_data, prdata_q, prdata_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             irq_pend_q, irq_pend_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  pixel_t           bg_q, bg_d;

  logic [FB_AW:0]   scan_addr;
  logic             tg_active, tg_hsync, tg_vsync, vblank, vblank_evt;

  pixel_t           mem [2**FB_AW];
  pixel_t           ram_a_q, ram_b_q;

  logic             s1_valid_q, s1_hs_q, s1_vs_q, s1_oob_q;
  logic             out_valid_q, out_hs_q, out_vs_q;
  pixel_t           out_rgb_q, out_rgb_d;

  logic             unused_ok;
  assign unused_ok = ^{in_pprot, in_pstrb[3], in_pwdata[31:24], in_paddr[31:FB_AW+3],
                       in_paddr[1:0]};

  // APB decode
  assign access   = in_psel & in_penable;
  assign fb_sel   = ~in_paddr[FB_AW+2];
  assign word_idx = in_paddr[FB_AW+1:2];
  assign reg_sel  = reg_sel_e'(in_paddr[3:2]);
  assign reg_err  = |(word_idx >> 2);

  // Framebuffer reads insert one wait state so the synchronous RAM can respond.
  assign fb_wait_d  = access & ~in_pwrite & fb_sel & ~fb_wait_q;
  assign in_pready  = access & (in_pwrite | ~fb_sel | fb_wait_q);
  assign done       = in_pready;
  assign rd_done    = done & ~in_pwrite;
  assign in_pslverr = done & ~fb_sel & reg_err;
  assign reg_we     = done & in_pwrite & ~fb_sel & ~reg_err;
  assign fb_we      = done & in_pwrite & fb_sel;

  always_comb begin
    reg_rdata = '0;
    if (!reg_err) begin
      unique case (reg_sel)
        RegCtrl:     reg_rdata[1:0] = ctrl_q;
        RegStatus: begin
          reg_rdata[StatusVblankBit] = vblank;
          reg_rdata[StatusIrqBit]    = irq_pend_q;
        end
        RegFrameCnt: reg_rdata[15:0] = frame_cnt_q;
        RegBgColor:  reg_rdata[23:0] = bg_q;
        default:     ;
      endcase
    end
  end

  assign rd_data   = fb_sel ? {8'h00, ram_a_q} : reg_rdata;
  assign prdata_d  = rd_done ? rd_data : prdata_q;
  assign in_prdata = prdata_d;

  always_comb begin
    ctrl_d      = ctrl_q;
    bg_d        = bg_q;
    irq_pend_d  = irq_pend_q;
    frame_cnt_d = frame_cnt_q;
    if (reg_we) begin
      unique case (reg_sel)
        RegCtrl:   if (in_pstrb[0]) ctrl_d = in_pwdata[1:0];
        RegStatus: if (in_pstrb[0] && in_pwdata[StatusIrqBit]) irq_pend_d = 1'b0;
        RegBgColor: begin
          for (int i = 0; i < 3; i++) begin
            if (in_pstrb[i]) bg_d[8*i +: 8] = in_pwdata[8*i +: 8];
          end
        end
        default: ;
      endcase
    end
    // The event is applied last so it wins over a simultaneous clear.
    if (vblank_evt) begin
      irq_pend_d  = 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_wait_q   <= 1'b0;
      prdata_q    <= '0;
      ctrl_q      <= '0;
      irq_pend_q  <= 1'b0;
      frame_cnt_q <= '0;
      bg_q        <= '0;
    end else begin
      fb_wait_q   <= fb_wait_d;
      prdata_q    <= prdata_d;
      ctrl_q      <= ctrl_d;
      irq_pend_q  <= irq_pend_d;
      frame_cnt_q <= frame_cnt_d;
      bg_q        <= bg_d;
    end
  end

  assign irq = irq_pend_q & ctrl_q[CtrlIrqEnBit];

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .FB_AW    (FB_AW),
    .PIX_DIV  (PIX_DIV),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (ctrl_q[CtrlEnBit]),
    .scan_addr  (scan_addr),
    .active     (tg_active),
    .hsync      (tg_hsync),
    .vsync      (tg_vsync),
    .vblank     (vblank),
    .vblank_evt (vblank_evt)
  );

  // Framebuffer contents are not reset; port B sees pre-write data on a collision.
  always_ff @(posedge clk) begin
    if (fb_we) begin
      for (int i = 0; i < 3; i++) begin
        if (in_pstrb[i]) mem[word_idx][8*i +: 8] <= in_pwdata[8*i +: 8];
      end
    end
    ram_a_q <= mem[word_idx];
    ram_b_q <= mem[scan_addr[FB_AW-1:0]];
  end

  assign out_rgb_d = s1_valid_q ? (s1_oob_q ? bg_q : ram_b_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_hs_q     <= ~SYNC_POL;
      s1_vs_q     <= ~SYNC_POL;
      s1_oob_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_hs_q    <= ~SYNC_POL;
      out_vs_q    <= ~SYNC_POL;
      out_rgb_q   <= '0;
    end else begin
      s1_valid_q  <= tg_active;
      s1_hs_q     <= tg_hsync;
      s1_vs_q     <= tg_vsync;
      s1_oob_q    <= scan_addr[FB_AW];
      out_valid_q <= s1_valid_q;
      out_hs_q    <= s1_hs_q;
      out_vs_q    <= s1_vs_q;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign vga_r     = out_rgb_q[23:16];
  assign vga_g     = out_rgb_q[15:8];
  assign vga_b     = out_rgb_q[7:0];
  assign vga_hsync = out_hs_q;
  assign vga_vsync = out_vs_q;
  assign vga_valid = out_valid_q;

endmodule

// File: tb/tb_vga_fb_apb.sv
// Directed bench for vga_fb_apb on a tiny 8x7 raster (4x4 active, 2 clocks/pixel,
// 8-word framebuffer): APB vector table plus scanout, irq and reset sequences.
module tb_vga_fb_apb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [2:0]  pprot = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [7:0]  vr, vg, vb;
  logic        hs, vs, vld, irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] pix_mem [8];

  vga_fb_apb #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .FB_AW    (3), .PIX_DIV (2), .SYNC_POL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_paddr   (paddr),
    .in_psel    (psel),
    .in_penable (penable),
    .in_pwrite  (pwrite),
    .in_pprot   (pprot),
    .in_pwdata  (pwdata),
    .in_pstrb   (pstrb),
    .in_pready  (pready),
    .in_prdata  (prdata),
    .in_pslverr (pslverr),
    .vga_r      (vr),
    .vga_g      (vg),
    .vga_b      (vb),
    .vga_hsync  (hs),
    .vga_vsync  (vs),
    .vga_valid  (vld),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] er, input logic ee,
                              input int ew);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.strb = s;
    v.exp_rd = er; v.exp_err = ee; v.exp_waits = ew;
    return v;
  endfunction

  // Cycle n = the period after the n-th rising edge since enable took effect.
  task automatic wait_cycle(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic err,
                     output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!pready && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    rd  = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Packs the pin-level outputs as {irq, hsync, vsync, valid, rgb}.
  function automatic logic [27:0] pins_exp(input int n, input logic ei);
    int m, f, line, px, p;
    logic ehs, evs, ev;
    logic [23:0] rgb;
    if (n < 2) return {ei, 1'b1, 1'b1, 1'b0, 24'h0};
    m    = n - 2;
    f    = m % 112;
    line = f / 16;
    px   = (f % 16) / 2;
    ehs  = !(px == 5 || px == 6);
    evs  = (line != 5);
    ev   = (px < 4) && (line < 4);
    p    = line * 4 + px;
    rgb  = !ev ? 24'h0 : (p < 8 ? pix_mem[p] : 24'h123456);
    return {ei, ehs, evs, ev, rgb};
  endfunction

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;
    int          hs_low, vld_cnt;

    pix_mem[0] = 24'h112233; pix_mem[1] = 24'h445566; pix_mem[2] = 24'h778899;
    pix_mem[3] = 24'hAABBCC; pix_mem[4] = 24'hDDEEF0; pix_mem[5] = 24'hA100C3;
    pix_mem[6] = 24'hDDEEFF; pix_mem[7] = 24'h0F1E2D;

    vecs.push_back(mk(1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h24, 32'h0, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h28, 32'h0, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h2C, 32'h0, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h00, 32'h00112233, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h04, 32'h00445566, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h08, 32'h00778899, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h0C, 32'h00AABBCC, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h10, 32'h00DDEEF0, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h14, 32'h00000000, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h1C, 32'h000F1E2D, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h14, 32'h00A1B2C3, 4'b0101, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h18, 32'hFFDDEEFF, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h14, 32'h0, 4'hF, 32'h00A100C3, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h18, 32'h0, 4'hF, 32'h00DDEEFF, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h00, 32'h0, 4'hF, 32'h00112233, 1'b0, 1));
    vecs.push_back(mk(1'b0, 32'h1C, 32'h0, 4'hF, 32'h000F1E2D, 1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h2C, 32'h00123456, 4'hF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h2C, 32'h0, 4'hF, 32'h00123456, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b1, 0));
    vecs.push_back(mk(1'b1, 32'h3C, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h2C, 32'h0, 4'hF, 32'h00123456, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h30, 32'h00000003, 4'hF, 32'h0, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0));

    // Reset values
    repeat (3) @(negedge clk);
    check("reset pins", {4'h0, irq, hs, vs, vld, vr, vg, vb}, {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0});
    check("reset apb", {pready, pslverr, prdata[29:0]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle pins", {4'h0, irq, hs, vs, vld, vr, vg, vb}, {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0});

    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, waits);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d pslverr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("vec%0d waits", i), waits, vecs[i].exp_waits);
    end

    // Enable scanout with irq_en; cycle 0 is the first period with enable set.
    apb(1'b1, 32'h20, 32'h3, 4'hF, rd, err, waits);
    base = cyc;
    hs_low = 0;
    vld_cnt = 0;
    for (int n = 0; n < 112; n++) begin
      wait_cycle(n);
      @(negedge clk);
      check($sformatf("scan cyc%0d", n), {4'h0, irq, hs, vs, vld, vr, vg, vb},
            {4'h0, pins_exp(n, n >= 64)});
      if (n >= 2 && n < 18 && !hs) hs_low++;
      if (vld) vld_cnt++;
    end
    check("hsync low clocks per line", hs_low, 4);
    check("valid clocks per frame", vld_cnt, 32);

    apb(1'b0, 32'h28, 32'h0, 4'hF, rd, err, waits);
    check("frame_cnt after 1st vblank", rd, 32'd1);
    apb(1'b1, 32'h24, 32'h2, 4'hF, rd, err, waits);
    @(negedge clk);
    check("irq after w1c", {31'h0, irq}, 32'h0);
    apb(1'b0, 32'h24, 32'h0, 4'hF, rd, err, waits);
    check("status in active area", rd, 32'h0);

    // W1C whose access cycle coincides with the second vblank event (cycle 175).
    wait_cycle(174);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h2; pstrb = 4'hF;
    wait_cycle(175);
    penable = 1'b1;
    @(negedge clk);
    check("w1c pready at event", {31'h0, pready}, 32'h1);
    check("irq before event", {31'h0, irq}, 32'h0);
    wait_cycle(176);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("irq set wins over w1c", {31'h0, irq}, 32'h1);
    apb(1'b0, 32'h28, 32'h0, 4'hF, rd, err, waits);
    check("frame_cnt after 2nd vblank", rd, 32'd2);
    apb(1'b0, 32'h24, 32'h0, 4'hF, rd, err, waits);
    check("status in vblank", rd, 32'h3);

    // Reset pulse mid-line while active pixels are on the pins.
    wait_cycle(229);
    @(negedge clk);
    check("pins before reset", {4'h0, irq, hs, vs, vld, vr, vg, vb}, {4'h0, pins_exp(229, 1'b1)});
    #2;
    rst_n = 1'b0;
    #1;
    check("pins in reset", {4'h0, irq, hs, vs, vld, vr, vg, vb}, {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0});
    check("prdata in reset", prdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apb(1'b0, 32'h20, 32'h0, 4'hF, rd, err, waits);
    check("ctrl after reset", rd, 32'h0);
    repeat (4) @(negedge clk);
    check("pins after reset", {4'h0, irq, hs, vs, vld, vr, vg, vb}, {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_apb.md
# vga_fb_apb

Parametrised APB VGA framebuffer controller: the next-generation display peripheral on the SoC APB bus. Holds a 24-bit RGB framebuffer and scans it out through a programmable-timing VGA generator. Adds control/status registers, a vblank interrupt with write-1-to-clear, a frame counter, a background colour and a pixel-clock divider. Framebuffer reads are pipelined with fixed output alignment.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch, in lines
- FB_AW, 19, framebuffer word-address width; depth is 2^FB_AW words of 24 bits
- PIX_DIV, 1, clocks per pixel (≥1)
- SYNC_POL, 0, sync active level (0 = active-low)
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low
- in_paddr  in  32  APB address
- in_psel, in_penable, in_pwrite  in  1  APB controls
- in_pprot  in  3  ignored
- in_pwdata  in  32  write data
- in_pstrb  in  4  byte strobes; bit 3 ignored
- in_pready  out  1  transfer complete
- in_prdata  out  32  read data
- in_pslverr  out  1  error response
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hsync, vga_vsync  out  1  sync outputs
- vga_valid  out  1  active-video flag
- irq  out  1  vblank interrupt, level

## Operation
- Address decode: in_paddr[FB_AW+2] = 0 selects the framebuffer, word index in_paddr[FB_AW+1:2]. A value of 1 selects registers by in_paddr[3:2].
- Registers:
  - CTRL (0x0): bit0 enable, bit1 irq_en; reset 0.
  - STATUS (0x4): bit0 vblank (RO), bit1 irq_pending (W1C).
  - FRAME_CNT (0x8): RO, 16 bits, wraps.
  - BG_COLOR (0xC): 24 bits, RW, reset 0.
- Any register access with in_paddr[FB_AW+1:4] ≠ 0 sets in_pslverr. Such writes have no effect; such reads return 0.
- Framebuffer writes honour pstrb[2:0] per byte. Reads return {8'h0, pixel}.
- Line order: active, front porch, sync, back porch. Counters x ∈ [0, H_TOTAL−1] and y ∈ [0, V_TOTAL−1] advance on the pixel enable, which fires every PIX_DIV clocks.
- Scan address: a linear counter reset to 0 at x=0,y=0. It increments once per active pixel, with no multiplier.
- If the scan address is ≥ 2^FB_AW, or the pixel is outside active video, the pixel data is BG_COLOR or black respectively.
- Sync is asserted at SYNC_POL while x is in the H sync region (respectively, y in the V sync region).
- enable = 0: counters, scan address and divider are held at 0. Syncs are at the inactive level; vga_valid and RGB are 0.
- enable 0→1: scanning starts at x=0, y=0.
- Vblank event: on the pixel enable where y becomes V_ACTIVE at x=0, irq_pending sets and FRAME_CNT increments. STATUS.vblank = (y ≥ V_ACTIVE).
- irq = irq_pending & irq_en.
- A W1C write in the same cycle as a vblank event leaves irq_pending set (set wins).
- The framebuffer has two ports: APB on port A, scanout on port B, read-only. A same-address collision returns the old data on port B.

## Timing
- Register accesses and all writes complete with zero wait states: in_pready = 1 in the access phase.
- Framebuffer reads take exactly one wait state: in_pready is 0 in the first access cycle and 1 in the second, with in_prdata valid then.
- in_pready is 0 whenever in_psel = 0. in_prdata is held between reads.
- Scanout pipeline: counter stage, then RAM read (1 clock), then output register. RGB, syncs and vga_valid all leave the output register.
- The total latency from counter state to pins is 2 clocks, identical for every signal.
- Reset values: RGB 0, vga_valid 0, syncs inactive (= ~SYNC_POL), irq 0, in_prdata 0, in_pslverr 0, all registers 0.
- Reset asserted mid-frame or mid-transfer clears counters, the pipeline and CTRL at once. Framebuffer contents are undefined afterwards and are not cleared.

## Structure
- Package vga_pkg holds:
  - register offset constants;
  - CTRL/STATUS bit indices;
  - the 24-bit pixel typedef;
  - derived H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_timing_gen holds the divider, x/y counters, scan address, sync/valid generation and the vblank event. The top level holds APB decode, the registers, the RAM and the output pipeline.

## Test plan
- Reset: after release, read CTRL, STATUS, FRAME_CNT and BG_COLOR → all 0, in_pready=1, no error. vga_hsync = vga_vsync = 1, irq=0.
- Write 0x00A1B2C3 to FB word 5 with pstrb=0101, then a full write to word 6. Read both → word 5 = 0x00A100C3 (byte1 unchanged from 0 after a prior 0 write), one wait state each.
- Small params (H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V=4/1/1/1, PIX_DIV=2), enable=1:
  - hsync low for exactly 4 clocks every 16 clocks;
  - vga_valid high 8 clocks per line on 4 lines;
  - first pixel at pins 2 clocks after the x=0 clock.
- FB_AW=3 with 16 active pixels and BG_COLOR=0x123456 → pixels 8–15 of the frame show 0x123456.
- irq_en=1: irq rises at the vblank event and FRAME_CNT goes to 1. A W1C written in that same cycle leaves irq=1; a W1C one frame later clears it.
- Register offset 0x10 read → in_pslverr=1, data 0.
- Reset pulse mid-line → outputs return to reset values immediately, CTRL=0.
